// File: rtl/mc_block_fetch.sv
// mc_block_fetch: motion-compensation block fetch.
//
// Buffers one 8x8 reference search area (raster order), takes a motion
// vector as two signed 3-bit beats (x, then y), then streams the predicted
// 4x4 block in raster order for 16 consecutive cycles.
//
// Optional build macro MC_RESIDUAL_EN: after the vector, 16 signed residual
// beats are collected and each output becomes clamp(pred + res, 0, max).
// With the macro undefined, res_valid / in_residual are accepted but unused.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   area_valid   in_data holds one area pixel
//   in_data      area pixel (PIX_W bits)
//   vec_valid    in_vector holds one vector beat (x first, then y)
//   in_vector    signed 3-bit vector component
//   res_valid    in_residual holds one residual beat (MC_RESIDUAL_EN only)
//   in_residual  signed 9-bit residual (MC_RESIDUAL_EN only)
//   out_valid    out_data holds a block pixel
//   out_data     predicted / reconstructed pixel (registered)
//
// Handshake: every input stream is valid-only (no ready). A beat is taken on
// the rising edge where its valid is high and the block is in the state that
// consumes that stream; beats offered in any other state are dropped. The
// output stream is valid-only too and never stalls: 16 back-to-back beats.
module mc_block_fetch #(
    parameter int PIX_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                area_valid,
    input  logic [PIX_W-1:0]    in_data,
    input  logic                vec_valid,
    input  logic signed [2:0]   in_vector,
    input  logic                res_valid,
    input  logic signed [8:0]   in_residual,
    output logic                out_valid,
    output logic [PIX_W-1:0]    out_data
);

    localparam logic [1:0] S_AREA = 2'd0;
    localparam logic [1:0] S_VEC  = 2'd1;
`ifdef MC_RESIDUAL_EN
    localparam logic [1:0] S_RES  = 2'd2;
`endif
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]       state;      // observable FSM state
    logic [5:0]       area_cnt;
    logic             vec_cnt;    // 0: expecting x, 1: expecting y
    logic [3:0]       blk_cnt;    // residual index in S_RES, output index in S_OUT
    logic [2:0]       col0;
    logic [2:0]       row0;
    logic [PIX_W-1:0] area_mem [64];

    // Window origin column = 2 + clamp(x); out-of-range codes saturate to +/-2.
    function automatic logic [2:0] decode_col(input logic signed [2:0] v);
        case (v)
            3'b100, 3'b101, 3'b110: decode_col = 3'd0;
            3'b111:                 decode_col = 3'd1;
            3'b000:                 decode_col = 3'd2;
            3'b001:                 decode_col = 3'd3;
            default:                decode_col = 3'd4;
        endcase
    endfunction

    // Window origin row = 2 - clamp(y); positive y moves the window up.
    function automatic logic [2:0] decode_row(input logic signed [2:0] v);
        case (v)
            3'b100, 3'b101, 3'b110: decode_row = 3'd4;
            3'b111:                 decode_row = 3'd3;
            3'b000:                 decode_row = 3'd2;
            3'b001:                 decode_row = 3'd1;
            default:                decode_row = 3'd0;
        endcase
    endfunction

    // Origin is at most 4, offset at most 3, so each sum fits in 3 bits and
    // the 6-bit area address is just {row, col}.
    logic [2:0]       rd_row;
    logic [2:0]       rd_col;
    logic [PIX_W-1:0] pred;
    logic [PIX_W-1:0] pix_out;

    assign rd_row = row0 + {1'b0, blk_cnt[3:2]};
    assign rd_col = col0 + {1'b0, blk_cnt[1:0]};
    assign pred   = area_mem[{rd_row, rd_col}];

`ifdef MC_RESIDUAL_EN
    localparam int SW = PIX_W + 2;

    logic signed [8:0]    res_mem [16];
    logic signed [8:0]    res_cur;
    logic signed [SW-1:0] sum;

    assign res_cur = res_mem[blk_cnt];
    assign sum     = $signed({2'b00, pred}) + $signed({{(SW-9){res_cur[8]}}, res_cur});

    always_comb begin
        pix_out = sum[PIX_W-1:0];
        if (sum[SW-1])
            pix_out = '0;
        else if (sum[SW-2:PIX_W] != '0)
            pix_out = '1;
    end

    always_ff @(posedge clk) begin
        if (state == S_RES && res_valid)
            res_mem[blk_cnt] <= in_residual;
    end
`else
    logic unused_res;
    assign unused_res = ^{res_valid, in_residual};
    assign pix_out    = pred;
`endif

    // Area storage carries no reset; contents are don't-care until refilled.
    always_ff @(posedge clk) begin
        if (state == S_AREA && area_valid)
            area_mem[area_cnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_AREA;
            area_cnt  <= '0;
            vec_cnt   <= 1'b0;
            blk_cnt   <= '0;
            col0      <= '0;
            row0      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            case (state)
                S_AREA: begin
                    if (area_valid) begin
                        area_cnt <= area_cnt + 6'd1;
                        if (area_cnt == 6'd63)
                            state <= S_VEC;
                    end
                end
                S_VEC: begin
                    if (vec_valid) begin
                        vec_cnt <= ~vec_cnt;
                        if (!vec_cnt) begin
                            col0 <= decode_col(in_vector);
                        end else begin
                            row0 <= decode_row(in_vector);
`ifdef MC_RESIDUAL_EN
                            state <= S_RES;
`else
                            state <= S_OUT;
`endif
                        end
                    end
                end
`ifdef MC_RESIDUAL_EN
                S_RES: begin
                    if (res_valid) begin
                        blk_cnt <= blk_cnt + 4'd1;
                        if (blk_cnt == 4'd15)
                            state <= S_OUT;
                    end
                end
`endif
                S_OUT: begin
                    out_valid <= 1'b1;
                    out_data  <= pix_out;
                    blk_cnt   <= blk_cnt + 4'd1;
                    if (blk_cnt == 4'd15)
                        state <= S_AREA;
                end
                default: state <= S_AREA;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_block_fetch.sv
module tb_mc_block_fetch;
  localparam int PIX_W = 8;
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              area_valid;
  logic [PIX_W-1:0]  in_data;
  logic              vec_valid;
  logic signed [2:0] in_vector;
  logic              res_valid;
  logic signed [8:0] in_residual;
  logic              out_valid;
  logic [PIX_W-1:0]  out_data;

  mc_block_fetch #(.PIX_W(PIX_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .area_valid  (area_valid),
    .in_data     (in_data),
    .vec_valid   (vec_valid),
    .in_vector   (in_vector),
    .res_valid   (res_valid),
    .in_residual (in_residual),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ref_area[64];
  int ref_res[16];
  logic [PIX_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // reference model: window origin from clamped vector, then plain indexing
  function automatic int clamp2(input int v);
    if (v < -2) return -2;
    if (v > 2) return 2;
    return v;
  endfunction

  function automatic void build_exp(input int x, input int y);
    int c0, r0, p;
    c0 = 2 + clamp2(x);
    r0 = 2 - clamp2(y);
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      p = ref_area[(r0 + k / 4) * 8 + c0 + k % 4] + ref_res[k];
      if (p < 0) p = 0;
      if (p > PIX_MAX) p = PIX_MAX;
      exp_q.push_back(p[PIX_W-1:0]);
    end
  endfunction

  // driver tasks: each starts and ends positioned at a falling edge
  task automatic clear_inputs();
    area_valid = 1'b0;
    vec_valid  = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic area_beat(input int pix);
    area_valid  = 1'b1;
    in_data     = pix[PIX_W-1:0];
    vec_valid   = 1'($urandom_range(0, 1));
    in_vector   = 3'($urandom_range(0, 7));
    res_valid   = 1'($urandom_range(0, 1));
    in_residual = 9'($urandom_range(0, 511));
    @(negedge clk);
    check("area_phase_valid", out_valid, 0);
    check("area_phase_data", out_data, 0);
  endtask

  task automatic vec_beat(input int v);
    vec_valid   = 1'b1;
    in_vector   = v[2:0];
    area_valid  = 1'($urandom_range(0, 1));
    in_data     = PIX_W'($urandom);
    res_valid   = 1'($urandom_range(0, 1));
    in_residual = 9'($urandom_range(0, 511));
    @(negedge clk);
  endtask

  task automatic res_beat(input int r);
    res_valid   = 1'b1;
    in_residual = r[8:0];
    area_valid  = 1'($urandom_range(0, 1));
    vec_valid   = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic send_area(input int gap);
    for (int i = 0; i < 64; i++) begin
      area_beat(ref_area[i]);
      idle(gap);
    end
  endtask

  task automatic send_vec(input int x, input int y, input int gap);
    vec_beat(x);
    idle(gap);
    vec_beat(y);
`ifdef MC_RESIDUAL_EN
    for (int i = 0; i < 16; i++) begin
      idle(gap);
      res_beat(ref_res[i]);
    end
`endif
  endtask

  // Called right after the edge that took the last input beat: output must be
  // idle there, then 16 gapless beats follow. Ends on the 16th output.
  task automatic check_block(input string tag);
    check({tag, "_latency"}, out_valid, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || k < 15) begin
        area_valid = 1'($urandom_range(0, 1));
        vec_valid  = 1'($urandom_range(0, 1));
        res_valid  = 1'($urandom_range(0, 1));
        in_data    = PIX_W'($urandom);
      end
      @(negedge clk);
      if (k == 15) clear_inputs();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, exp_q[k]);
    end
    clear_inputs();
  endtask

  task automatic check_tail(input string tag);
    clear_inputs();
    @(negedge clk);
    check({tag, "_tail_valid"}, out_valid, 0);
    check({tag, "_tail_data"}, out_data, 0);
  endtask

  task automatic txn(input int x, input int y, input int gap, input string tag);
    send_area(gap);
    send_vec(x, y, gap);
    build_exp(x, y);
    clear_inputs();
    check_block(tag);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) ref_res[k] = 0;
    rst = 1'b1;
    in_data = '0;
    in_vector = '0;
    in_residual = '0;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    rst = 1'b0;

    // 1: index area, zero vector
    for (int i = 0; i < 64; i++) ref_area[i] = i;
    txn(0, 0, 0, "t1_zero");
    check_tail("t1");

    // 2: corner windows
    txn(-2, 2, 0, "t2_top_left");
    check_tail("t2a");
    txn(2, -2, 0, "t2_bottom_right");
    check_tail("t2b");

    // 3: clamped codes with idle gaps
    txn(3, -4, 3, "t3_clamp_gaps");
    check_tail("t3");

    // 4: reset during output beat 5, then a fresh transaction
    send_area(0);
    send_vec(-1, 1, 0);
    build_exp(-1, 1);
    clear_inputs();
    check("t4_latency", out_valid, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_pre_reset", out_data, exp_q[k]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_reset_valid", out_valid, 0);
    check("t4_reset_data", out_data, 0);
    for (int i = 0; i < 64; i++) ref_area[i] = i;
    txn(1, 1, 0, "t4_after_reset");

    // 5: back-to-back, next area starts right after the 16th output
    for (int i = 0; i < 64; i++) ref_area[i] = int'($urandom_range(0, PIX_MAX));
    txn(-1, 2, 0, "t5_second");
    check_tail("t5");

    // random transactions
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 64; i++) ref_area[i] = int'($urandom_range(0, PIX_MAX));
`ifdef MC_RESIDUAL_EN
      for (int k = 0; k < 16; k++) ref_res[k] = int'($urandom_range(0, 511)) - 256;
`endif
      txn(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4,
          int'($urandom_range(0, 2)), "rand");
      if (t % 2 == 1) check_tail("rand");
    end
    check_tail("rand_end");

`ifdef MC_RESIDUAL_EN
    // 6: residual saturation high, low, and zero residual
    for (int i = 0; i < 64; i++) ref_area[i] = 250;
    for (int k = 0; k < 16; k++) ref_res[k] = 10;
    txn(0, 0, 1, "t6_sat_high");
    check_tail("t6a");
    for (int i = 0; i < 64; i++) ref_area[i] = 5;
    for (int k = 0; k < 16; k++) ref_res[k] = -9;
    txn(1, -1, 0, "t6_sat_low");
    check_tail("t6b");
    for (int i = 0; i < 64; i++) ref_area[i] = int'($urandom_range(0, PIX_MAX));
    for (int k = 0; k < 16; k++) ref_res[k] = 0;
    txn(2, 1, 0, "t6_zero_res");
    check_tail("t6c");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
